multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the multicycle RV32I core. Sequences each instruction through
//  FETCH/DECODE/EXEC/MEM/WB, drives register-file, PC, IR and memory enables, and
//  configures the immediate generator through a one-hot imm_op select.
//  Sits between the instruction register and the shared datapath (ALU, RF, immediate
//  generator, unified memory port).
// PARAMETERS
//  MAX_WAIT   255  memory wait cycles tolerated per request before bus error (1..255)
// PORTS
//  clk        in   1   core clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  instr      in   32  current IR contents (valid from DECODE onward)
//  mem_ready  in   1   memory ack for the current mem_req; single-cycle pulse
//  br_taken   in   1   branch comparison result from ALU, valid in EXEC
//  mem_req    out  1   memory request (fetch or data), held until mem_ready
//  mem_we     out  1   store request, qualifies mem_req
//  ir_we      out  1   load IR from memory read data
//  rf_we      out  1   register-file write enable
//  pc_we      out  1   PC update, one pulse per retired instruction
//  pc_sel     out  2   0: pc+4   1: pc+imm (branch taken, JAL)   2: ALU result (JALR)
//  alu_src    out  1   0: rs2   1: imm
//  wb_sel     out  2   0: ALU   1: load data   2: pc+4
//  imm_op     out  6   one-hot immediate format: [5]shamt [4]I [3]S [2]B [1]U [0]J, 0=none
//  halted     out  1   core halted (bus error or trap); sticky until rst
//  bus_err    out  1   sticky: memory timeout caused the halt
// BEHAVIOUR
//  - Reset: while rst=1, every output is 0. State <= FETCH, wait_cnt <= 0.
//    Reset mid-instruction abandons the instruction; no pc_we or rf_we is issued.
//  - Outputs are Moore, decoded from state. Exception: imm_op is decoded from instr in
//    DECODE, EXEC, MEM and WB; it is 0 in FETCH and HALT.
//  - FETCH: mem_req=1, mem_we=0. On mem_ready: ir_we=1, next state DECODE.
//  - DECODE: exactly one cycle. Next state is EXEC for legal opcodes.
//  - EXEC (one cycle), by class:
//      ALU-R/ALU-I/LUI/AUIPC/JAL/JALR -> WB
//      LOAD/STORE                     -> MEM
//      BRANCH: pc_we=1, pc_sel = br_taken ? 1 : 0, -> FETCH
//  - MEM: mem_req=1, mem_we=1 for STORE. On mem_ready: LOAD -> WB; STORE -> pc_we=1,
//    pc_sel=0, -> FETCH.
//  - WB: rf_we=1 (suppressed when rd==0), pc_we=1, -> FETCH.
//      JAL: pc_sel=1, wb_sel=2.  JALR: pc_sel=2, wb_sel=2.
//      LOAD: wb_sel=1.  Otherwise: wb_sel=0, pc_sel=0.
//  - imm_op map: shift-imm (funct3 001/101 on OP-IMM) -> [5]; other OP-IMM, LOAD,
//    JALR -> [4]; STORE -> [3]; BRANCH -> [2]; LUI, AUIPC -> [1]; JAL -> [0]; R-type -> 0.
//  - alu_src=1 for every class except R-type and BRANCH.
//  - wait_cnt: 8-bit counter, cleared on state entry, increments each FETCH/MEM cycle
//    while mem_ready=0. If wait_cnt reaches MAX_WAIT with mem_ready=0: mem_req drops,
//    state -> HALT, bus_err=1. mem_ready arriving in the MAX_WAIT-th cycle itself is
//    accepted and no error is raised.
//  - HALT: halted=1; all enables 0; only rst exits.
//  - mem_ready outside FETCH/MEM is ignored.
// CONFIGURATION
//  - MC_ILLEGAL_TRAP_EN defined: an unrecognised opcode in DECODE -> HALT, halted=1,
//    bus_err=0.
//  - MC_ILLEGAL_TRAP_EN undefined: an unrecognised opcode executes as a NOP:
//    DECODE issues pc_we=1, pc_sel=0, then -> FETCH. halted never rises for this cause.
// STRUCTURE
//  - Package cpu_pkg: opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC,
//    JAL, JALR), IMM_* one-hot codes, PC_SEL_*/WB_SEL_* codes, state encoding.
//  - Sub-module imm_op_decode: combinational instr -> imm_op, class and legal flag.
//    Shared with the single-cycle control.
// TESTING
//  1. addi x1,x0,5 (0x00500093), mem_ready one cycle after each req -> states
//     F,D,E,W; imm_op=010000; rf_we and pc_we pulse in WB, pc_sel=0.
//  2. lw x2,0(x1) (0x0000A103), data mem_ready delayed 3 cycles -> mem_req held 4
//     cycles in MEM; wb_sel=1 in WB; no pulses before that.
//  3. sw x2,4(x1) (0x0020A223) -> mem_we=1 in MEM; imm_op=001000; rf_we never asserted.
//  4. beq x0,x0,8 (0x00000463) with br_taken=1, then with 0 -> pc_sel=1 / 0; imm_op=000100.
//  5. jal x1,16 (0x010000EF) -> imm_op=000001; WB: pc_sel=1, wb_sel=2, rf_we=1.
//  6. MAX_WAIT=4, mem_ready held low in FETCH -> HALT after 4 cycles, bus_err=halted=1.
//     Instr 0x00000000: HALT with MC_ILLEGAL_TRAP_EN, NOP without it.
//     rst pulse in MEM -> all outputs 0, restart at FETCH.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared opcodes, immediate-format codes, mux selects and FSM state
//           encoding for the RV32I multicycle and single-cycle control.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;

   localparam logic [5:0] IMM_NONE  = 6'b000000;
   localparam logic [5:0] IMM_SHAMT = 6'b100000;
   localparam logic [5:0] IMM_I     = 6'b010000;
   localparam logic [5:0] IMM_S     = 6'b001000;
   localparam logic [5:0] IMM_B     = 6'b000100;
   localparam logic [5:0] IMM_U     = 6'b000010;
   localparam logic [5:0] IMM_J     = 6'b000001;

   localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
   localparam logic [1:0] PC_SEL_IMM   = 2'd1;
   localparam logic [1:0] PC_SEL_ALU   = 2'd2;

   localparam logic [1:0] WB_SEL_ALU  = 2'd0;
   localparam logic [1:0] WB_SEL_LOAD = 2'd1;
   localparam logic [1:0] WB_SEL_PC4  = 2'd2;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      CLS_ALU_R   = 4'd0,
      CLS_ALU_I   = 4'd1,
      CLS_LOAD    = 4'd2,
      CLS_STORE   = 4'd3,
      CLS_BRANCH  = 4'd4,
      CLS_LUI     = 4'd5,
      CLS_AUIPC   = 4'd6,
      CLS_JAL     = 4'd7,
      CLS_JALR    = 4'd8,
      CLS_ILLEGAL = 4'd9
   } instr_class_t;

endpackage

`default_nettype wire

// File: rtl/imm_op_decode.sv
// ============================================================================
// Module  : imm_op_decode
// Brief   : Combinational opcode decode: instruction class, legal flag and
//           one-hot immediate-format select.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module imm_op_decode
   import cpu_pkg::*;
(
   input  logic [31:0]  instr_i,
   output logic [5:0]   imm_op_o,
   output instr_class_t cls_o,
   output logic         legal_o
);

   logic [6:0] opcode_w;
   logic [2:0] funct3_w;
   logic       unused_w;

   assign opcode_w = instr_i[6:0];
   assign funct3_w = instr_i[14:12];
   assign unused_w = ^{instr_i[31:15], instr_i[11:7]};

   always_comb begin
      imm_op_o = IMM_NONE;
      cls_o    = CLS_ILLEGAL;
      legal_o  = 1'b1;
      case (opcode_w)
         OP:     cls_o = CLS_ALU_R;
         OP_IMM: begin
            cls_o    = CLS_ALU_I;
            // SLLI/SRLI/SRAI carry a 5-bit shamt rather than a full I immediate
            imm_op_o = (funct3_w == 3'b001 || funct3_w == 3'b101) ? IMM_SHAMT : IMM_I;
         end
         LOAD:   begin cls_o = CLS_LOAD;   imm_op_o = IMM_I; end
         STORE:  begin cls_o = CLS_STORE;  imm_op_o = IMM_S; end
         BRANCH: begin cls_o = CLS_BRANCH; imm_op_o = IMM_B; end
         LUI:    begin cls_o = CLS_LUI;    imm_op_o = IMM_U; end
         AUIPC:  begin cls_o = CLS_AUIPC;  imm_op_o = IMM_U; end
         JAL:    begin cls_o = CLS_JAL;    imm_op_o = IMM_J; end
         JALR:   begin cls_o = CLS_JALR;   imm_op_o = IMM_I; end
         default: legal_o = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module  : multicycle_ctrl
// Brief   : Main FETCH/DECODE/EXEC/MEM/WB control FSM of the multicycle RV32I
//           core with memory-timeout bus error. Define MC_ILLEGAL_TRAP_EN to
//           halt on unrecognised opcodes (otherwise they retire as NOPs).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_i,
   input  logic        mem_ready_i,
   input  logic        br_taken_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic        ir_we_o,
   output logic        rf_we_o,
   output logic        pc_we_o,
   output logic [1:0]  pc_sel_o,
   output logic        alu_src_o,
   output logic [1:0]  wb_sel_o,
   output logic [5:0]  imm_op_o,
   output logic        halted_o,
   output logic        bus_err_o
);

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t       state_q, state_d;
   logic [7:0]   wait_cnt_q;
   logic         bus_err_q;
   logic [5:0]   dec_imm_w;
   instr_class_t cls_w;
   logic         legal_w;
   logic         mem_phase_w;
   logic         timeout_w;
   logic         rd_nz_w;
   logic         alu_imm_w;

   imm_op_decode u_imm_op_decode (
      .instr_i  (instr_i),
      .imm_op_o (dec_imm_w),
      .cls_o    (cls_w),
      .legal_o  (legal_w)
   );

   assign mem_phase_w = (state_q == ST_FETCH) || (state_q == ST_MEM);
   // The MAX_WAIT-th waiting cycle is the last one; a ready in that cycle still wins
   assign timeout_w   = mem_phase_w && !mem_ready_i && (wait_cnt_q == WAIT_LAST);
   assign rd_nz_w     = (instr_i[11:7] != 5'd0);
   assign alu_imm_w   = legal_w && (cls_w != CLS_ALU_R) && (cls_w != CLS_BRANCH);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: begin
            if (mem_ready_i)    state_d = ST_DECODE;
            else if (timeout_w) state_d = ST_HALT;
         end
         ST_DECODE: begin
            if (legal_w) state_d = ST_EXEC;
`ifdef MC_ILLEGAL_TRAP_EN
            else         state_d = ST_HALT;
`else
            else         state_d = ST_FETCH;
`endif
         end
         ST_EXEC: begin
            case (cls_w)
               CLS_LOAD, CLS_STORE: state_d = ST_MEM;
               CLS_BRANCH:          state_d = ST_FETCH;
               default:             state_d = ST_WB;
            endcase
         end
         ST_MEM: begin
            if (mem_ready_i)    state_d = (cls_w == CLS_LOAD) ? ST_WB : ST_FETCH;
            else if (timeout_w) state_d = ST_HALT;
         end
         ST_WB:   state_d = ST_FETCH;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FETCH;
         wait_cnt_q <= 8'd0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q)
            wait_cnt_q <= 8'd0;
         else if (mem_phase_w && !mem_ready_i)
            wait_cnt_q <= wait_cnt_q + 8'd1;
         if (timeout_w)
            bus_err_q <= 1'b1;
      end
   end

   always_comb begin
      mem_req_o = 1'b0;
      mem_we_o  = 1'b0;
      ir_we_o   = 1'b0;
      rf_we_o   = 1'b0;
      pc_we_o   = 1'b0;
      pc_sel_o  = PC_SEL_PLUS4;
      alu_src_o = 1'b0;
      wb_sel_o  = WB_SEL_ALU;
      imm_op_o  = IMM_NONE;
      halted_o  = 1'b0;
      bus_err_o = 1'b0;
      if (!rst) begin
         bus_err_o = bus_err_q;
         if (state_q != ST_FETCH && state_q != ST_HALT) begin
            imm_op_o  = dec_imm_w;
            alu_src_o = alu_imm_w;
         end
         case (state_q)
            ST_FETCH: begin
               mem_req_o = 1'b1;
               ir_we_o   = mem_ready_i;
            end
            ST_DECODE: begin
`ifndef MC_ILLEGAL_TRAP_EN
               pc_we_o = !legal_w;
`endif
            end
            ST_EXEC: begin
               if (cls_w == CLS_BRANCH) begin
                  pc_we_o  = 1'b1;
                  pc_sel_o = br_taken_i ? PC_SEL_IMM : PC_SEL_PLUS4;
               end
            end
            ST_MEM: begin
               mem_req_o = 1'b1;
               mem_we_o  = (cls_w == CLS_STORE);
               pc_we_o   = mem_ready_i && (cls_w == CLS_STORE);
            end
            ST_WB: begin
               rf_we_o = rd_nz_w;
               pc_we_o = 1'b1;
               case (cls_w)
                  CLS_JAL:  begin pc_sel_o = PC_SEL_IMM; wb_sel_o = WB_SEL_PC4; end
                  CLS_JALR: begin pc_sel_o = PC_SEL_ALU; wb_sel_o = WB_SEL_PC4; end
                  CLS_LOAD: wb_sel_o = WB_SEL_LOAD;
                  default:  wb_sel_o = WB_SEL_ALU;
               endcase
            end
            ST_HALT: halted_o = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module  : tb_multicycle_ctrl
// Brief   : Directed scoreboard bench for multicycle_ctrl (MAX_WAIT=4);
//           expectations follow MC_ILLEGAL_TRAP_EN when it is defined.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

   localparam logic [5:0]  I_NONE = 6'b000000;
   localparam logic [5:0]  I_SH   = 6'b100000;
   localparam logic [5:0]  I_I    = 6'b010000;
   localparam logic [5:0]  I_S    = 6'b001000;
   localparam logic [5:0]  I_B    = 6'b000100;
   localparam logic [5:0]  I_J    = 6'b000001;
   localparam logic [17:0] ZERO   = 18'd0;

   localparam logic [31:0] ADDI   = 32'h00500093;
   localparam logic [31:0] LW     = 32'h0000A103;
   localparam logic [31:0] SW     = 32'h0020A223;
   localparam logic [31:0] BEQ    = 32'h00000463;
   localparam logic [31:0] JALI   = 32'h010000EF;
   localparam logic [31:0] NOPX0  = 32'h00000013;
   localparam logic [31:0] SLLI   = 32'h00309093;
   localparam logic [31:0] ILL    = 32'h00000000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = 32'd0;
   logic        mem_ready = 1'b0;
   logic        br_taken = 1'b0;
   logic        mem_req, mem_we, ir_we, rf_we, pc_we, alu_src, halted, bus_err;
   logic [1:0]  pc_sel, wb_sel;
   logic [5:0]  imm_op;
   logic [17:0] obs;

   int          checks = 0;
   int          errors = 0;
   logic [17:0] exp_q[$];

   always #5 clk = ~clk;

   multicycle_ctrl #(.MAX_WAIT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_i     (instr),
      .mem_ready_i (mem_ready),
      .br_taken_i  (br_taken),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .ir_we_o     (ir_we),
      .rf_we_o     (rf_we),
      .pc_we_o     (pc_we),
      .pc_sel_o    (pc_sel),
      .alu_src_o   (alu_src),
      .wb_sel_o    (wb_sel),
      .imm_op_o    (imm_op),
      .halted_o    (halted),
      .bus_err_o   (bus_err)
   );

   assign obs = {mem_req, mem_we, ir_we, rf_we, pc_we, pc_sel, alu_src, wb_sel, imm_op, halted, bus_err};

   // Field order: req we ir rf pcwe pcsel alusrc wbsel imm halted buserr
   function automatic logic [17:0] ev(input logic req, input logic we, input logic ir,
                                      input logic rf, input logic pw, input logic [1:0] ps,
                                      input logic as, input logic [1:0] ws,
                                      input logic [5:0] imm, input logic h, input logic be);
      return {req, we, ir, rf, pw, ps, as, ws, imm, h, be};
   endfunction

   task automatic step(input string tag, input logic r, input logic [31:0] ins,
                       input logic rdy, input logic br, input logic [17:0] e);
      logic [17:0] x;
      rst       = r;
      instr     = ins;
      mem_ready = rdy;
      br_taken  = br;
      exp_q.push_back(e);
      @(negedge clk);
      x = exp_q.pop_front();
      checks++;
      assert (obs === x) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, x);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [17:0] fetch_wait, fetch_ack;
      fetch_wait = ev(1,0,0,0,0,2'd0,0,2'd0,I_NONE,0,0);
      fetch_ack  = ev(1,0,1,0,0,2'd0,0,2'd0,I_NONE,0,0);
      #1;
      step("rst_a", 1, ADDI, 1, 1, ZERO);
      step("rst_b", 1, ADDI, 1, 0, ZERO);

      step("addi_F0", 0, ADDI, 0, 0, fetch_wait);
      step("addi_F1", 0, ADDI, 1, 0, fetch_ack);
      step("addi_D",  0, ADDI, 0, 0, ev(0,0,0,0,0,2'd0,1,2'd0,I_I,0,0));
      step("addi_E",  0, ADDI, 0, 0, ev(0,0,0,0,0,2'd0,1,2'd0,I_I,0,0));
      step("addi_W",  0, ADDI, 0, 0, ev(0,0,0,1,1,2'd0,1,2'd0,I_I,0,0));

      step("lw_F",  0, LW, 1, 0, fetch_ack);
      step("lw_D",  0, LW, 0, 0, ev(0,0,0,0,0,2'd0,1,2'd0,I_I,0,0));
      step("lw_E",  0, LW, 0, 0, ev(0,0,0,0,0,2'd0,1,2'd0,I_I,0,0));
      for (int i = 0; i < 3; i++)
         step("lw_Mwait", 0, LW, 0, 0, ev(1,0,0,0,0,2'd0,1,2'd0,I_I,0,0));
      step("lw_Mack", 0, LW, 1, 0, ev(1,0,0,0,0,2'd0,1,2'd0,I_I,0,0));
      step("lw_W",    0, LW, 0, 0, ev(0,0,0,1,1,2'd0,1,2'd1,I_I,0,0));

      step("sw_F", 0, SW, 1, 0, fetch_ack);
      step("sw_D", 0, SW, 0, 0, ev(0,0,0,0,0,2'd0,1,2'd0,I_S,0,0));
      step("sw_E", 0, SW, 0, 0, ev(0,0,0,0,0,2'd0,1,2'd0,I_S,0,0));
      step("sw_M", 0, SW, 1, 0, ev(1,1,0,0,1,2'd0,1,2'd0,I_S,0,0));

      step("beqT_F", 0, BEQ, 1, 0, fetch_ack);
      step("beqT_D", 0, BEQ, 1, 0, ev(0,0,0,0,0,2'd0,0,2'd0,I_B,0,0));
      step("beqT_E", 0, BEQ, 1, 1, ev(0,0,0,0,1,2'd1,0,2'd0,I_B,0,0));
      step("beqN_F", 0, BEQ, 1, 0, fetch_ack);
      step("beqN_D", 0, BEQ, 0, 0, ev(0,0,0,0,0,2'd0,0,2'd0,I_B,0,0));
      step("beqN_E", 0, BEQ, 1, 0, ev(0,0,0,0,1,2'd0,0,2'd0,I_B,0,0));

      step("jal_F", 0, JALI, 1, 0, fetch_ack);
      step("jal_D", 0, JALI, 0, 0, ev(0,0,0,0,0,2'd0,1,2'd0,I_J,0,0));
      step("jal_E", 0, JALI, 0, 0, ev(0,0,0,0,0,2'd0,1,2'd0,I_J,0,0));
      step("jal_W", 0, JALI, 0, 0, ev(0,0,0,1,1,2'd1,1,2'd2,I_J,0,0));

      step("x0_F", 0, NOPX0, 1, 0, fetch_ack);
      step("x0_D", 0, NOPX0, 0, 0, ev(0,0,0,0,0,2'd0,1,2'd0,I_I,0,0));
      step("x0_E", 0, NOPX0, 0, 0, ev(0,0,0,0,0,2'd0,1,2'd0,I_I,0,0));
      step("x0_W", 0, NOPX0, 0, 0, ev(0,0,0,0,1,2'd0,1,2'd0,I_I,0,0));

      step("slli_F", 0, SLLI, 1, 0, fetch_ack);
      step("slli_D", 0, SLLI, 0, 0, ev(0,0,0,0,0,2'd0,1,2'd0,I_SH,0,0));
      step("slli_E", 0, SLLI, 0, 0, ev(0,0,0,0,0,2'd0,1,2'd0,I_SH,0,0));
      step("slli_W", 0, SLLI, 0, 0, ev(0,0,0,1,1,2'd0,1,2'd0,I_SH,0,0));

      step("ill_F", 0, ILL, 1, 0, fetch_ack);
`ifdef MC_ILLEGAL_TRAP_EN
      step("ill_D",    0, ILL, 0, 0, ZERO);
      step("ill_H0",   0, ILL, 1, 0, ev(0,0,0,0,0,2'd0,0,2'd0,I_NONE,1,0));
      step("ill_H1",   0, ILL, 0, 0, ev(0,0,0,0,0,2'd0,0,2'd0,I_NONE,1,0));
      step("ill_rst",  1, ILL, 0, 0, ZERO);
`else
      step("ill_D",    0, ILL, 0, 0, ev(0,0,0,0,1,2'd0,0,2'd0,I_NONE,0,0));
`endif

      step("rlw_F",  0, LW, 1, 0, fetch_ack);
      step("rlw_D",  0, LW, 0, 0, ev(0,0,0,0,0,2'd0,1,2'd0,I_I,0,0));
      step("rlw_E",  0, LW, 0, 0, ev(0,0,0,0,0,2'd0,1,2'd0,I_I,0,0));
      step("rlw_M",  0, LW, 0, 0, ev(1,0,0,0,0,2'd0,1,2'd0,I_I,0,0));
      step("rlw_rst", 1, LW, 1, 0, ZERO);

      for (int i = 0; i < 4; i++)
         step("to_Fwait", 0, ADDI, 0, 0, fetch_wait);
      step("to_H0", 0, ADDI, 0, 0, ev(0,0,0,0,0,2'd0,0,2'd0,I_NONE,1,1));
      step("to_H1", 0, ADDI, 1, 0, ev(0,0,0,0,0,2'd0,0,2'd0,I_NONE,1,1));
      step("to_rst", 1, ADDI, 0, 0, ZERO);
      step("to_F",   0, ADDI, 0, 0, fetch_wait);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
